apb4_mem_slave: RTL and testbench

- Parametrised APB4 memory-mapped slave: configurable data width, depth and wait states.
- Adds byte strobes (pstrb) and error response (pslverr) on out-of-range or misaligned access.
- Sits on the peripheral APB segment as the standard register/scratch memory target, driven directly by the APB master or bridge.

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_mem_array.sv | 44 ++++
 rtl/apb4_mem_slave.sv | 111 +++++++++++
 tb/tb_apb4_mem_slave.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and address-decode helpers for the APB4 memory slave.
package apb_pkg;

    typedef enum logic {IDLE, ACCESS} apb_state_e;

    localparam int unsigned MAX_WAIT_STATES = 15;

    function automatic logic [63:0] word_index(input logic [63:0] addr, input int unsigned ofs);
        return addr >> ofs;
    endfunction

    // Misaligned (non-zero byte offset) or beyond the last implemented word.
    function automatic logic addr_err(input logic [63:0] addr, input int unsigned depth,
                                      input int unsigned ofs);
        logic [63:0] ofs_mask;
        ofs_mask = (64'd1 << ofs) - 64'd1;
        return ((addr & ofs_mask) != 64'd0) || (word_index(addr, ofs) >= 64'(depth));
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W word storage with per-byte write enables and a registered read port.
module apb_mem_array #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32,
    parameter int AW     = 8
) (
    input  logic                pclk,
    input  logic                init,
    input  logic                rd_en,
    input  logic [AW-1:0]       rd_idx,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                we,
    input  logic [AW-1:0]       wr_idx,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage is reset to a known pattern, so it maps to flops rather
    // than a RAM macro; a RAM-backed variant would need an init sequencer instead.
    always_ff @(posedge pclk) begin
        if (init) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= DATA_W'(i);
            end
            rd_data <= '0;
        end else begin
            if (we) begin
                for (int b = 0; b < NB; b++) begin
                    if (be[b]) begin
                        mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            if (rd_en) begin
                rd_data <= mem[rd_idx];
            end
        end
    end

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 memory-mapped slave: byte strobes, configurable wait states, error on bad address.
module apb4_mem_slave
    import apb_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic                pready,
    output logic [DATA_W-1:0]   prdata,
    output logic                pslverr
);

    localparam int OFS = $clog2(DATA_W / 8);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    apb_state_e        state;
    logic [3:0]        cnt;
    logic              wr_q;
    logic              err_q;
    logic [AW-1:0]     idx_q;
    logic [63:0]       addr64;
    logic              err_now;
    logic [AW-1:0]     idx_now;
    logic              setup;
    logic              complete;
    logic [DATA_W-1:0] rd_data;

    assign addr64   = 64'(paddr);
    assign err_now  = addr_err(addr64, DEPTH, OFS);
    // Out-of-range indices are never used for access, so truncation is safe.
    assign idx_now  = AW'(word_index(addr64, OFS));
    assign setup    = (state == IDLE) && psel && !penable;
    assign complete = (state == ACCESS) && (cnt == 4'd0);

    // pready is registered, so prdata only needs gating by registered state.
    assign prdata = (pready && !wr_q && !err_q) ? rd_data : '0;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    if (setup) begin
                        state   <= ACCESS;
                        wr_q    <= pwrite;
                        err_q   <= err_now;
                        idx_q   <= idx_now;
                        cnt     <= 4'(WAIT_STATES);
                        pready  <= (WAIT_STATES == 0);
                        pslverr <= (WAIT_STATES == 0) && err_now;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state   <= IDLE;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                    end else if (!psel) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            pready  <= 1'b1;
                            pslverr <= err_q;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    apb_mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_mem (
        .pclk    (pclk),
        .init    (rst),
        .rd_en   (setup && !pwrite && !err_now),
        .rd_idx  (idx_now),
        .rd_data (rd_data),
        .we      (complete && wr_q && !err_q),
        .wr_idx  (idx_q),
        .be      (pstrb),
        .wdata   (pwdata)
    );

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Directed bench: three slaves with 0, 3 and 2 wait states on a shared APB bus.
module tb_apb4_mem_slave;

    localparam int WS0 = 0;
    localparam int WS3 = 1;
    localparam int WS2 = 2;

    logic        pclk;
    logic        rst;
    logic [11:0] paddr;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready_v  [3];
    logic [31:0] prdata_v  [3];
    logic        pslverr_v [3];

    int n_cmp = 0;
    int n_err = 0;

    apb4_mem_slave #(.ADDR_W(12), .DATA_W(32), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .pclk(pclk), .rst(rst), .paddr(paddr), .psel(psel[WS0]), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready_v[WS0]), .prdata(prdata_v[WS0]), .pslverr(pslverr_v[WS0]));

    apb4_mem_slave #(.ADDR_W(12), .DATA_W(32), .DEPTH(256), .WAIT_STATES(3)) u_ws3 (
        .pclk(pclk), .rst(rst), .paddr(paddr), .psel(psel[WS3]), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready_v[WS3]), .prdata(prdata_v[WS3]), .pslverr(pslverr_v[WS3]));

    apb4_mem_slave #(.ADDR_W(12), .DATA_W(32), .DEPTH(256), .WAIT_STATES(2)) u_ws2 (
        .pclk(pclk), .rst(rst), .paddr(paddr), .psel(psel[WS2]), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready_v[WS2]), .prdata(prdata_v[WS2]), .pslverr(pslverr_v[WS2]));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Full transfer starting #1 after a rising edge; returns #1 after the completion edge.
    task automatic xfer(input int d, input logic wr, input logic [11:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic er, output int waits);
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        pstrb   = st;
        @(posedge pclk); #1;
        penable = 1'b1;
        waits   = 0;
        while (pready_v[d] !== 1'b1 && waits < 40) begin
            chk("wait_prdata_zero", prdata_v[d], 32'h0);
            chk("wait_pslverr_zero", 32'(pslverr_v[d]), 32'h0);
            @(posedge pclk); #1;
            waits++;
        end
        if (waits >= 40) chk("pready_timeout", 32'(pready_v[d]), 32'h1);
        rd = prdata_v[d];
        er = pslverr_v[d];
        @(posedge pclk); #1;
        chk("pready_one_cycle", 32'(pready_v[d]), 32'h0);
        psel[d] = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          w;

        rst = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        repeat (3) @(posedge pclk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_pready", 32'(pready_v[d]), 32'h0);
            chk("rst_prdata", prdata_v[d], 32'h0);
            chk("rst_pslverr", 32'(pslverr_v[d]), 32'h0);
        end
        rst = 1'b0;

        // Zero-wait read of the reset pattern.
        xfer(WS0, 1'b0, 12'h010, 32'h0, 4'h0, rd, er, w);
        chk("rd010_waits", 32'(w), 32'd0);
        chk("rd010_data", rd, 32'h0000_0004);
        chk("rd010_err", 32'(er), 32'h0);

        // Byte-strobe write merges bytes 0 and 2 into the initial 0x00000008.
        xfer(WS0, 1'b1, 12'h020, 32'hAABB_CCDD, 4'b0101, rd, er, w);
        chk("wr020_err", 32'(er), 32'h0);
        chk("wr020_prdata", rd, 32'h0);
        xfer(WS0, 1'b0, 12'h020, 32'h0, 4'h0, rd, er, w);
        chk("rd020_data", rd, 32'h00BB_00DD);

        // Three wait states, then a back-to-back read with no idle cycle.
        xfer(WS3, 1'b0, 12'h004, 32'h0, 4'h0, rd, er, w);
        chk("ws3_rd004_waits", 32'(w), 32'd3);
        chk("ws3_rd004_data", rd, 32'h0000_0001);
        xfer(WS3, 1'b0, 12'h008, 32'h0, 4'h0, rd, er, w);
        chk("ws3_rd008_waits", 32'(w), 32'd3);
        chk("ws3_rd008_data", rd, 32'h0000_0002);

        // Full-word write with wait states, used later for the reset check.
        xfer(WS3, 1'b1, 12'h060, 32'h1234_5678, 4'hF, rd, er, w);
        chk("ws3_wr060_err", 32'(er), 32'h0);
        xfer(WS3, 1'b0, 12'h060, 32'h0, 4'h0, rd, er, w);
        chk("ws3_rd060_data", rd, 32'h1234_5678);

        // Error responses.
        xfer(WS0, 1'b0, 12'h002, 32'h0, 4'h0, rd, er, w);
        chk("misalign_err", 32'(er), 32'h1);
        chk("misalign_data", rd, 32'h0);
        xfer(WS0, 1'b1, 12'h400, 32'hFFFF_FFFF, 4'hF, rd, er, w);
        chk("oob_wr_err", 32'(er), 32'h1);
        xfer(WS0, 1'b1, 12'h3FE, 32'hFFFF_FFFF, 4'hF, rd, er, w);
        chk("misalign_wr_err", 32'(er), 32'h1);
        xfer(WS0, 1'b0, 12'hFFC, 32'h0, 4'h0, rd, er, w);
        chk("oob_rd_err", 32'(er), 32'h1);
        chk("oob_rd_data", rd, 32'h0);

        // Valid write with no strobes: no change, no error.
        xfer(WS0, 1'b1, 12'h040, 32'hDEAD_BEEF, 4'h0, rd, er, w);
        chk("nostrb_err", 32'(er), 32'h0);

        // Scan: only word 8 differs from its index.
        for (int i = 0; i < 256; i++) begin
            xfer(WS0, 1'b0, 12'(i * 4), 32'h0, 4'h0, rd, er, w);
            chk("scan", rd, (i == 8) ? 32'h00BB_00DD : 32'(i));
        end

        // Abort: psel dropped during the first ACCESS cycle.
        psel[WS2] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h030; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        chk("abort_acc1_pready", 32'(pready_v[WS2]), 32'h0);
        psel[WS2] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge pclk); #1;
            chk("abort_no_pready", 32'(pready_v[WS2]), 32'h0);
        end
        penable = 1'b0;
        xfer(WS2, 1'b0, 12'h030, 32'h0, 4'h0, rd, er, w);
        chk("abort_rd030_waits", 32'(w), 32'd2);
        chk("abort_rd030_data", rd, 32'h0000_000C);

        // Reset while a zero-wait read is presenting its data.
        psel[WS0] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h010;
        @(posedge pclk); #1;
        penable = 1'b1;
        chk("pre_rst_pready", 32'(pready_v[WS0]), 32'h1);
        chk("pre_rst_prdata", prdata_v[WS0], 32'h0000_0004);
        rst = 1'b1;
        @(posedge pclk); #1;
        chk("mid_rst_pready", 32'(pready_v[WS0]), 32'h0);
        chk("mid_rst_prdata", prdata_v[WS0], 32'h0);
        chk("mid_rst_pslverr", 32'(pslverr_v[WS0]), 32'h0);
        rst = 1'b0; psel = '0; penable = 1'b0;
        @(posedge pclk); #1;

        xfer(WS0, 1'b0, 12'h020, 32'h0, 4'h0, rd, er, w);
        chk("post_rst_rd020", rd, 32'h0000_0008);
        xfer(WS3, 1'b0, 12'h060, 32'h0, 4'h0, rd, er, w);
        chk("post_rst_rd060", rd, 32'h0000_0018);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
